instr_reg: RTL
==============

// Module: instr_reg
// PURPOSE
//  Instruction register and memory data register for the 8-bit multicycle core. Sits between byte-wide
//  memory and the controller. Assembles a 32-bit instruction from four byte loads strobed by the
//  controller's irwrite[3:0]. Feeds op[5:0] back to the controller and decoded fields to the datapath.
//  Tracks fetch sequencing, flags illegal strobe patterns and counts completed fetches.
// PARAMETERS
//  WIDTH   8   memory data / byte width; instruction width = 4*WIDTH
//  CNT_W   16  width of completed-fetch counter
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        reset; asynchronous, active-low
//  memdata       in   WIDTH    byte returned by memory
//  irwrite       in   4        byte-lane write strobes from controller (bit i -> instr[8i+7:8i])
//  instr         out  32       assembled instruction register
//  op            out  6        instr[31:26], to controller
//  rs            out  5        instr[25:21]
//  rt            out  5        instr[20:16]
//  rd            out  5        instr[15:11]
//  funct         out  6        instr[5:0]
//  imm           out  WIDTH    instr[7:0], immediate / branch offset
//  mdr           out  WIDTH    memory data register
//  instr_valid   out  1        all four bytes of the current fetch loaded in order
//  seq_err       out  1        sticky: illegal irwrite pattern seen since reset
//  fetch_cnt     out  CNT_W    number of completed in-order fetches, wraps
// BEHAVIOUR
//  Reset (rst=0, async): instr=0 (op=000000), mdr=0, instr_valid=0, seq_err=0, fetch_cnt=0, state=EMPTY.
//  All outputs are registered or pure slices of instr; no combinational path from irwrite to outputs.
//  mdr <= memdata every clock edge, unconditionally, with 1-cycle latency.
//  Byte write: for each i with irwrite[i]=1, instr[8i+7:8i] <= memdata at the edge. This holds for every
//   mask, including illegal ones. Bytes with irwrite[i]=0 hold their value.
//  Sequencing FSM states: EMPTY, GOT1, GOT2, GOT3, FULL.
//   irwrite==0000          : hold state.
//   irwrite==0001          : -> GOT1 from any state. Restarts the fetch; legal from EMPTY/FULL.
//                            From GOT1..GOT3 this is an abandoned fetch: seq_err <= 1.
//   irwrite==0010 in GOT1  : -> GOT2.
//   irwrite==0100 in GOT2  : -> GOT3.
//   irwrite==1000 in GOT3  : -> FULL; fetch_cnt <= fetch_cnt+1 (wraps 2^CNT_W-1 -> 0).
//   any other nonzero mask : -> EMPTY; seq_err <= 1. This covers a wrong lane, a multi-bit mask, or a
//                            lane strobed in FULL/EMPTY.
//  instr_valid = (state==FULL). It rises on the edge that writes byte 3 and is visible in the cycle after
//   irwrite[3]. It falls on the edge of the next irwrite[0] or illegal mask.
//  seq_err clears only on reset.
//  Reset mid-fill: instr clears immediately; FSM -> EMPTY; a later strobe not equal to 0001 is an error.
//  Decoded fields are always driven from instr, whether or not instr_valid is set; the controller
//   samples op only after FETCH4.
// TESTING
//  1 Reset: rst=0 mid-clock -> all outputs 0 without waiting for an edge; release; idle 5 cycles -> unchanged.
//  2 Ordered fetch: memdata 20,10,82,80 with irwrite 0001,0010,0100,1000 on consecutive cycles
//     -> instr=0x80821020, op=100000 (LB), rt=00010, imm=0x20; instr_valid=1 the cycle after the 4th
//     strobe; fetch_cnt=1; seq_err=0.
//  3 Back-to-back: second fetch 08,00,00,20 right after 2 -> valid drops on its 0001 edge, reasserts
//     with instr=0x20000008, op=001000 (ADDI); fetch_cnt=2.
//  4 Illegal: after GOT1, irwrite=0100 with memdata=AA -> instr[23:16]=AA, state EMPTY, instr_valid=0,
//     seq_err=1 sticky through a subsequent good fetch. Repeat with irwrite=0011 -> both lanes written.
//  5 Abandon: 0001,0010 then 0001 -> seq_err=1, state GOT1; completing 0010,0100,1000 -> valid=1, count+1.
//  6 Wrap/reset: CNT_W=2, run 4 fetches -> fetch_cnt 1,2,3,0. Assert rst during GOT2 -> instr=0;
//     after release, irwrite=0010 -> seq_err=1.
//  mdr: drive a memdata ramp -> mdr equals the previous cycle's memdata every cycle.

Source files
------------

// File: rtl/instr_reg.sv
// instr_reg
//   Instruction register and memory data register for the 8-bit multicycle core.
//   Four byte loads, strobed by the controller's irwrite lanes, assemble one
//   instruction. A small sequencer tracks whether the bytes arrived in order
//   (lane 0, 1, 2, 3). It flags any illegal strobe pattern and counts
//   completed fetches.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   memdata_i    byte returned by memory
//   irwrite_i    byte-lane write strobes (bit i loads instr[8i+7:8i])
//   instr_o      assembled instruction register
//   op_o         instr[31:26], back to the controller
//   rs_o         instr[25:21]
//   rt_o         instr[20:16]
//   rd_o         instr[15:11]
//   funct_o      instr[5:0]
//   imm_o        instr[7:0], immediate / branch offset
//   mdr_o        memory data register (memdata delayed one cycle)
//   instr_valid_o all four bytes of the current fetch loaded in order
//   seq_err_o    sticky flag: an illegal strobe pattern was seen since reset
//   fetch_cnt_o  number of completed in-order fetches (wraps)
module instr_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   memdata_i,
  input  logic [3:0]         irwrite_i,
  output logic [4*WIDTH-1:0] instr_o,
  output logic [5:0]         op_o,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [5:0]         funct_o,
  output logic [WIDTH-1:0]   imm_o,
  output logic [WIDTH-1:0]   mdr_o,
  output logic               instr_valid_o,
  output logic               seq_err_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  localparam int IW = 4 * WIDTH;

  typedef enum logic [2:0] {
    EMPTY,
    GOT1,
    GOT2,
    GOT3,
    FULL
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic [WIDTH-1:0] mdr_q;
  logic             seqErr_q, seqErr_d;
  logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;

  // Every strobed lane loads memdata, even when the mask is illegal. The
  // sequencer only judges the ordering; it never blocks a write.
  always_comb begin
    instr_d = instr_q;
    for (int i = 0; i < 4; i++) begin
      if (irwrite_i[i]) begin
        instr_d[i*WIDTH +: WIDTH] = memdata_i;
      end
    end
  end

  // Fetch sequencer. Lane 0 always restarts a fetch. If a fetch was already
  // in progress, restarting it abandons that fetch, which counts as an error.
  // Any strobe other than the next expected lane drops back to EMPTY.
  always_comb begin
    state_d    = state_q;
    seqErr_d   = seqErr_q;
    fetchCnt_d = fetchCnt_q;
    case (irwrite_i)
      4'b0000: begin
        state_d = state_q;
      end
      4'b0001: begin
        state_d = GOT1;
        if (state_q == GOT1 || state_q == GOT2 || state_q == GOT3) begin
          seqErr_d = 1'b1;
        end
      end
      4'b0010: begin
        if (state_q == GOT1) begin
          state_d = GOT2;
        end else begin
          state_d  = EMPTY;
          seqErr_d = 1'b1;
        end
      end
      4'b0100: begin
        if (state_q == GOT2) begin
          state_d = GOT3;
        end else begin
          state_d  = EMPTY;
          seqErr_d = 1'b1;
        end
      end
      4'b1000: begin
        if (state_q == GOT3) begin
          state_d    = FULL;
          fetchCnt_d = fetchCnt_q + CNT_W'(1);
        end else begin
          state_d  = EMPTY;
          seqErr_d = 1'b1;
        end
      end
      default: begin
        state_d  = EMPTY;
        seqErr_d = 1'b1;
      end
    endcase
  end

  // All state lives here. The MDR samples memdata unconditionally every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      instr_q    <= '0;
      mdr_q      <= '0;
      seqErr_q   <= 1'b0;
      fetchCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      mdr_q      <= memdata_i;
      seqErr_q   <= seqErr_d;
      fetchCnt_q <= fetchCnt_d;
    end
  end

  // Decoded fields are plain slices of the register. The controller decides
  // when op is meaningful.
  assign instr_o       = instr_q;
  assign op_o          = instr_q[IW-1 -: 6];
  assign rs_o          = instr_q[IW-7 -: 5];
  assign rt_o          = instr_q[IW-12 -: 5];
  assign rd_o          = instr_q[IW-17 -: 5];
  assign funct_o       = instr_q[5:0];
  assign imm_o         = instr_q[WIDTH-1:0];
  assign mdr_o         = mdr_q;
  assign instr_valid_o = (state_q == FULL);
  assign seq_err_o     = seqErr_q;
  assign fetch_cnt_o   = fetchCnt_q;

endmodule
